// File: rtl/pcie_dma_rd_pkg.sv
// Shared constants, FSM encoding and last-beat lane mask for the DMA read path.
package pcie_dma_rd_pkg;

  localparam int DW_PER_LINE     = 4;
  localparam int MAX_LEN_DW      = 512;
  localparam int LINE_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // len[1:0] == 0 means the final beat is full (len is a multiple of 4)
  function automatic logic [3:0] last_dw_mask(input logic [1:0] len_lo);
    case (len_lo)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/pcie_dma_rd_line_fifo.sv
// Small synchronous FIFO holding returned RAM lines; show-ahead read port, count output.
// Push and pop may coincide; the caller's credit scheme keeps it from overflowing.
module pcie_dma_rd_line_fifo
  import pcie_dma_rd_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = LINE_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/pcie_dma_rd_ctrl.sv
// BAR read controller: fetch 128b lines, realign so the first DW sits in lane 0, stream payload beats.
// First beat 3 cycles after accept (4 if unaligned); reads throttled by line-FIFO credit under backpressure.
module pcie_dma_rd_ctrl
  import pcie_dma_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_start,
  input  logic [9:0]            i_length,
  input  logic [63:0]           i_addr,
  input  logic [1:0]            i_bar_hit,
  output logic                  o_busy,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [1:0]            o_rd_bar_hit,
  input  logic [127:0]          i_rd_data,
  output logic                  o_cpl_valid,
  input  logic                  i_cpl_ready,
  output logic [127:0]          o_cpl_data,
  output logic [3:0]            o_cpl_dw_vld,
  output logic                  o_cpl_last
);

  localparam int CNT_W = $clog2(LINE_FIFO_DEPTH + 1);

  rd_state_e             state_q, state_d;
  logic [1:0]            off_q;
  logic [1:0]            len_lo_q;
  logic [7:0]            n_rd_q;
  logic [7:0]            n_out_q;
  logic [7:0]            rd_cnt_q;
  logic [7:0]            beat_cnt_q;
  logic [ADDR_WIDTH-1:0] line_q;
  logic [1:0]            bar_q;
  logic                  rd_inflight_q;
  logic [127:0]          prev_q;
  logic                  prev_vld_q;

  logic [CNT_W-1:0]      fifo_cnt;
  logic [127:0]          fifo_head;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CNT_W:0]        occupancy;

  logic                  len_legal;
  logic                  accept;
  logic [10:0]           nrd_sum;
  logic [10:0]           nout_sum;
  logic                  rd_en;
  logic                  lines_done;
  logic                  cpl_vld;
  logic                  fire;
  logic                  is_last;
  logic [127:0]          cur_line;
  logic [127:0]          beat;
  logic                  unused_bits;

  assign len_legal = (i_length != 10'd0) && (i_length <= 10'(MAX_LEN_DW));
  assign accept    = (state_q == ST_IDLE) && i_rd_start && len_legal;
  assign nrd_sum   = {1'b0, i_length} + {9'b0, i_addr[3:2]} + 11'(DW_PER_LINE - 1);
  assign nout_sum  = {1'b0, i_length} + 11'(DW_PER_LINE - 1);

  // Credit counts lines already buffered plus the one possibly still coming back from RAM
  assign occupancy  = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign rd_en      = (state_q == ST_READ) && (occupancy < (CNT_W+1)'(LINE_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign lines_done = (state_q == ST_DRAIN) && !rd_inflight_q && fifo_empty;

  // Unaligned: a beat needs prev plus either the next line or, after the last line, zeros
  assign cpl_vld = (state_q != ST_IDLE) && (beat_cnt_q != n_out_q) &&
                   ((off_q == 2'd0) ? !fifo_empty : (prev_vld_q && (!fifo_empty || lines_done)));
  assign fire     = cpl_vld && i_cpl_ready;
  assign is_last  = (beat_cnt_q == n_out_q - 8'd1);
  assign fifo_pop = (off_q == 2'd0) ? fire : (!fifo_empty && (!prev_vld_q || fire));
  assign cur_line = fifo_empty ? 128'b0 : fifo_head;

  always_comb begin
    beat = fifo_head;
    case (off_q)
      2'd1:    beat = {cur_line[31:0], prev_q[127:32]};
      2'd2:    beat = {cur_line[63:0], prev_q[127:64]};
      2'd3:    beat = {cur_line[95:0], prev_q[127:96]};
      default: beat = fifo_head;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  if (rd_en && (rd_cnt_q == n_rd_q - 8'd1)) state_d = ST_DRAIN;
      ST_DRAIN: if (fire && is_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      off_q         <= '0;
      len_lo_q      <= '0;
      n_rd_q        <= '0;
      n_out_q       <= '0;
      rd_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      line_q        <= '0;
      bar_q         <= '0;
      rd_inflight_q <= 1'b0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= rd_en;
      if (accept) begin
        off_q      <= i_addr[3:2];
        len_lo_q   <= i_length[1:0];
        n_rd_q     <= nrd_sum[9:2];
        n_out_q    <= nout_sum[9:2];
        line_q     <= i_addr[ADDR_WIDTH+3:4];
        bar_q      <= i_bar_hit;
        rd_cnt_q   <= '0;
        beat_cnt_q <= '0;
        prev_vld_q <= 1'b0;
      end else begin
        if (rd_en) begin
          line_q   <= line_q + ADDR_WIDTH'(1);
          rd_cnt_q <= rd_cnt_q + 8'd1;
        end
        if (fire) beat_cnt_q <= beat_cnt_q + 8'd1;
        if (fifo_pop && (off_q != 2'd0)) begin
          prev_q     <= fifo_head;
          prev_vld_q <= 1'b1;
        end
      end
    end
  end

  pcie_dma_rd_line_fifo #(
    .WIDTH (128),
    .DEPTH (LINE_FIFO_DEPTH)
  ) u_line_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight_q),
    .push_data (i_rd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_cnt)
  );

  assign o_busy       = (state_q != ST_IDLE);
  assign o_rd_en      = rd_en;
  assign o_rd_addr    = line_q;
  assign o_rd_bar_hit = bar_q;
  assign o_cpl_valid  = cpl_vld;
  assign o_cpl_data   = cpl_vld ? beat : 128'b0;
  assign o_cpl_dw_vld = cpl_vld ? (is_last ? last_dw_mask(len_lo_q) : 4'b1111) : 4'b0000;
  assign o_cpl_last   = cpl_vld && is_last;

  assign unused_bits = ^{i_addr[63:ADDR_WIDTH+4], i_addr[1:0],
                         nrd_sum[10], nrd_sum[1:0], nout_sum[10], nout_sum[1:0]};

endmodule

// File: tb/tb_pcie_dma_rd_ctrl.sv
// Directed bench for pcie_dma_rd_ctrl with a 1-cycle-latency RAM model whose DW value encodes line and lane.
module tb_pcie_dma_rd_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd_start;
  logic [9:0]    i_length;
  logic [63:0]   i_addr;
  logic [1:0]    i_bar_hit;
  logic          o_busy;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [1:0]    o_rd_bar_hit;
  logic [127:0]  i_rd_data = '0;
  logic          o_cpl_valid;
  logic          i_cpl_ready;
  logic [127:0]  o_cpl_data;
  logic [3:0]    o_cpl_dw_vld;
  logic          o_cpl_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] bdat [$];
  logic [3:0]   bmask [$];
  logic         blast [$];
  int           raddr [$];
  int           first_rd, first_vld, last_fire, fall_cyc, credit_viol, stall_viol;
  logic         busy1;
  logic [1:0]   bar1;

  pcie_dma_rd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_start   (i_rd_start),
    .i_length     (i_length),
    .i_addr       (i_addr),
    .i_bar_hit    (i_bar_hit),
    .o_busy       (o_busy),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .o_rd_bar_hit (o_rd_bar_hit),
    .i_rd_data    (i_rd_data),
    .o_cpl_valid  (o_cpl_valid),
    .i_cpl_ready  (i_cpl_ready),
    .o_cpl_data   (o_cpl_data),
    .o_cpl_dw_vld (o_cpl_dw_vld),
    .o_cpl_last   (o_cpl_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dw_val(input int line, input int lane);
    return 32'hA000_0000 | 32'(line << 8) | 32'(lane);
  endfunction

  always @(posedge clk) begin
    if (o_rd_en)
      i_rd_data <= {dw_val(int'(o_rd_addr), 3), dw_val(int'(o_rd_addr), 2),
                    dw_val(int'(o_rd_addr), 1), dw_val(int'(o_rd_addr), 0)};
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DW k of the request lives at absolute DW index addr/4 + k, modulo the RAM size
  function automatic logic [127:0] exp_beat(input logic [63:0] addr, input int len, input int b);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int k;
      int a;
      k = b * 4 + j;
      a = int'(addr[AW+3:2]) + k;
      if (k < len) r[32*j +: 32] = dw_val((a / 4) % (1 << AW), a % 4);
    end
    return r;
  endfunction

  task automatic run_req(input logic [63:0] addr, input logic [9:0] len, input logic [1:0] bar,
                         input bit alt_ready, input int ign_cyc, input int abort_beat);
    logic pv, pr, plast;
    logic [127:0] pd;
    logic [3:0] pm;
    int issued, acc, lim;
    bdat.delete(); bmask.delete(); blast.delete(); raddr.delete();
    first_rd = -1; first_vld = -1; last_fire = -1; fall_cyc = -1;
    credit_viol = 0; stall_viol = 0; busy1 = 1'b0; bar1 = 2'b00;
    pv = 1'b0; pr = 1'b1; plast = 1'b0; pd = '0; pm = '0; issued = 0; acc = 0;
    lim = (addr[3:2] != 2'd0) ? 5 : 4;
    i_rd_start = 1'b1; i_addr = addr; i_length = len; i_bar_hit = bar;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      i_rd_start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        i_addr = 64'h100; i_length = 10'd3; i_bar_hit = 2'b11;
      end
      i_cpl_ready = alt_ready ? ((cyc % 4) < 2) : 1'b1;
      #1;
      if (cyc == 1) begin
        busy1 = o_busy; bar1 = o_rd_bar_hit;
      end
      if (o_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (issued - acc >= lim) credit_viol++;
        raddr.push_back(int'(o_rd_addr));
        issued++;
      end
      if (pv && !pr && (!o_cpl_valid || o_cpl_data !== pd || o_cpl_dw_vld !== pm || o_cpl_last !== plast))
        stall_viol++;
      if (o_cpl_valid && first_vld < 0) first_vld = cyc;
      if (o_cpl_valid && i_cpl_ready) begin
        bdat.push_back(o_cpl_data); bmask.push_back(o_cpl_dw_vld); blast.push_back(o_cpl_last);
        acc++;
        if (o_cpl_last) last_fire = cyc;
      end
      if (acc == abort_beat) break;
      if (last_fire >= 0 && cyc > last_fire && !o_busy) begin
        fall_cyc = cyc;
        break;
      end
      pv = o_cpl_valid; pr = i_cpl_ready; pd = o_cpl_data; pm = o_cpl_dw_vld; plast = o_cpl_last;
    end
    i_rd_start = 1'b0;
  endtask

  task automatic check_beats(input string tag, input logic [63:0] addr, input int len);
    int nout;
    int rem;
    nout = (len + 3) / 4;
    rem  = len - 4 * (nout - 1);
    check({tag, ".nbeats"}, bdat.size(), nout);
    check({tag, ".fall"}, fall_cyc, last_fire + 1);
    for (int b = 0; b < bdat.size() && b < nout; b++) begin
      logic [3:0] em;
      logic [127:0] lm;
      em = (b == nout - 1) ? 4'((1 << rem) - 1) : 4'b1111;
      for (int j = 0; j < 4; j++) lm[32*j +: 32] = {32{em[j]}};
      check($sformatf("%s.dat%0d", tag, b), bdat[b] & lm, exp_beat(addr, len, b));
      check($sformatf("%s.msk%0d", tag, b), bmask[b], em);
      check($sformatf("%s.lst%0d", tag, b), blast[b], (b == nout - 1));
    end
  endtask

  task automatic watch(input int n, output int busy_cnt, output int act_cnt);
    busy_cnt = 0; act_cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2;
      if (o_busy) busy_cnt++;
      if (o_rd_en || o_cpl_valid) act_cnt++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bc, ac;
    rst = 1'b1; i_rd_start = 1'b0; i_length = '0; i_addr = '0; i_bar_hit = '0; i_cpl_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", o_busy, 0);
    check("rst.rd_en", o_rd_en, 0);
    check("rst.valid", {o_cpl_valid, o_cpl_last, o_cpl_dw_vld}, 0);
    check("rst.data", o_cpl_data, 0);
    check("rst.addr", {o_rd_bar_hit, o_rd_addr}, 0);
    rst = 1'b0;

    // aligned single DW
    run_req(64'h40, 10'd1, 2'b10, 1'b0, 0, -1);
    check("t1.busy1", busy1, 1);
    check("t1.bar", bar1, 2'b10);
    check("t1.first_rd", first_rd, 1);
    check("t1.nrd", raddr.size(), 1);
    check("t1.line", raddr[0], 4);
    check("t1.first_vld", first_vld, 3);
    check("t1.nbeats", bdat.size(), 1);
    check("t1.dw0", bdat[0][31:0], 32'hA000_0400);
    check("t1.msk", bmask[0], 4'b0001);
    check("t1.last", blast[0], 1);
    check("t1.fall", fall_cyc, last_fire + 1);

    // off=3, two lines folded into one beat; issued in the cycle busy falls
    run_req(64'h0C, 10'd4, 2'b01, 1'b0, 0, -1);
    check("t2.first_rd", first_rd, 1);
    check("t2.nrd", raddr.size(), 2);
    check("t2.first_vld", first_vld, 4);
    check("t2.nbeats", bdat.size(), 1);
    check("t2.dat", bdat[0], 128'hA0000102_A0000101_A0000100_A0000003);
    check("t2.msk", bmask[0], 4'b1111);
    check("t2.last", blast[0], 1);

    // off=1, len=7: N_out == N_rd so a zero-filled tail beat follows
    run_req(64'h04, 10'd7, 2'b01, 1'b0, 0, -1);
    check("t3.first_rd", first_rd, 1);
    check("t3.nbeats", bdat.size(), 2);
    check("t3.dat0", bdat[0], 128'hA0000100_A0000003_A0000002_A0000001);
    check("t3.msk0", bmask[0], 4'b1111);
    check("t3.lst0", blast[0], 0);
    check("t3.dat1", bdat[1] & 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF,
          128'h00000000_A0000103_A0000102_A0000101);
    check("t3.msk1", bmask[1], 4'b0111);
    check("t3.lst1", blast[1], 1);

    // max length with ready 50% duty
    run_req(64'h0, 10'd512, 2'b01, 1'b1, 0, -1);
    check_beats("t4", 64'h0, 512);
    check("t4.nrd", raddr.size(), 128);
    check("t4.credit", credit_viol, 0);
    check("t4.stall", stall_viol, 0);

    // line address wrap, plus a start strobe while busy
    run_req(64'h1FF0, 10'd8, 2'b01, 1'b0, 2, -1);
    check("t5.rd0", raddr[0], 511);
    check("t5.rd1", raddr[1], 0);
    check_beats("t5", 64'h1FF0, 8);
    watch(6, bc, ac);
    check("t5.no_queue_busy", bc, 0);
    check("t5.no_queue_act", ac, 0);

    // illegal lengths are dropped
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      i_rd_start = 1'b1; i_addr = 64'h80; i_length = (t == 0) ? 10'd0 : 10'd513;
      @(posedge clk); #1;
      i_rd_start = 1'b0;
      #1;
      check($sformatf("t6.busy%0d", t), o_busy, 0);
      watch(5, bc, ac);
      check($sformatf("t6.act%0d", t), ac + bc, 0);
    end

    // reset after beat 3 of 16
    run_req(64'h200, 10'd64, 2'b01, 1'b0, 0, 3);
    check("t7.beats_before_rst", bdat.size(), 3);
    rst = 1'b1;
    #1;
    check("t7.rst_ctl", {o_busy, o_rd_en, o_cpl_valid, o_cpl_last, o_cpl_dw_vld}, 0);
    check("t7.rst_data", o_cpl_data, 0);
    check("t7.rst_addr", {o_rd_bar_hit, o_rd_addr}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    watch(8, bc, ac);
    check("t7.quiet", ac + bc, 0);
    run_req(64'h30, 10'd6, 2'b01, 1'b0, 0, -1);
    check("t7.first_rd", first_rd, 1);
    check_beats("t7b", 64'h30, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
